// File: rtl/xor_arb_pkg.sv
// Shared constants for the round-robin XOR arbiter: FSM encoding, ID and counter widths,
// and the saturating increment used by the optional XOR_ARB_CNT_EN transfer counter.
package xor_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam int ID_W  = 3;
    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/xor_arb_xor8bit.sv
// One 8-bit slice of the shared XOR datapath; wider operands tile several slices.
module xor8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_arb.sv
// Round-robin arbiter in front of a single shared XOR datapath with a one-deep result register.
// Optional macro XOR_ARB_CNT_EN enables the saturating completed-transfer counter on op_count.
module xor_arb
    import xor_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]          out_id,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         op_count
);

    logic [0:0]      r_state;
    logic [ID_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [ID_W-1:0] r_out_id;

    logic            w_found;
    logic [ID_W-1:0] w_sel_idx;
    logic [3:0]      w_cand;
    logic            w_grant_en;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_b_sel;
    logic [WIDTH-1:0] w_xor;

    // Search starts at r_ptr and wraps; the first requester found wins.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + 4'(k);
            if (w_cand >= 4'(NUM_REQ))
                w_cand = w_cand - 4'(NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req[i] && (w_cand == 4'(i))) begin
                    w_found   = 1'b1;
                    w_sel_idx = ID_W'(i);
                end
            end
        end
    end

    // A held result blocks new grants unless it is being accepted on this same edge.
    assign w_grant_en = !reset && w_found && ((r_state == ST_IDLE) || out_ready);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt[gi] = w_grant_en && (w_sel_idx == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel_idx == ID_W'(i)) begin
                w_a_sel = a_in[i*WIDTH +: WIDTH];
                w_b_sel = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH/8; gi++) begin : g_xor
            xor8bit u_xor8bit (
                .a (w_a_sel[gi*8 +: 8]),
                .b (w_b_sel[gi*8 +: 8]),
                .y (w_xor[gi*8 +: 8])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_out_data <= '0;
            r_out_id   <= '0;
        end else if (w_grant_en) begin
            r_state    <= ST_HOLD;
            r_out_data <= w_xor;
            r_out_id   <= w_sel_idx;
            r_ptr      <= (w_sel_idx == ID_W'(NUM_REQ-1)) ? '0 : w_sel_idx + ID_W'(1);
        end else if ((r_state == ST_HOLD) && out_ready) begin
            r_state <= ST_IDLE;
        end
    end

    assign out_valid = (r_state == ST_HOLD);
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

`ifdef XOR_ARB_CNT_EN
    logic [CNT_W-1:0] r_op_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_op_count <= '0;
        else if (out_valid && out_ready)
            r_op_count <= sat_inc(r_op_count);
    end

    assign op_count = r_op_count;
`else
    assign op_count = '0;
`endif

endmodule

// File: tb/tb_xor_arb.sv
// Self-checking bench for xor_arb (NUM_REQ=4, WIDTH=8); a grant-time scoreboard holds expected
// results until accepted. Saturation checks run only when XOR_ARB_CNT_EN is defined.
module tb_xor_arb;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] data;
    } exp_t;

`ifdef XOR_ARB_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_id;
    logic        out_ready;
    logic [15:0] op_count;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t q[$];
    bit   m_hold;
    int   m_ptr;
    int   m_cnt;
    logic [7:0] m_last_data;
    logic [2:0] m_last_id;
    bit   quiet = 1'b0;

    xor_arb #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_gnt();
        if (reset) return 4'b0000;
        if (m_hold && !out_ready) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (req[idx]) return 4'(1 << idx);
        end
        return 4'b0000;
    endfunction

    // Advances one clock and updates the reference model; comparisons live in the test tasks.
    task automatic advance();
        logic [3:0] g;
        exp_t       e;
        g = model_gnt();
        @(posedge clk);
        if (reset) begin
            m_hold = 1'b0; m_ptr = 0; m_cnt = 0; q.delete();
            m_last_data = '0; m_last_id = '0;
        end else begin
            if (m_hold && out_ready) begin
                void'(q.pop_front());
                if (CNT_EN && m_cnt < 65535) m_cnt++;
            end
            if (g != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (g[i]) begin
                        e.id   = 3'(i);
                        e.data = a_in[i*8 +: 8] ^ b_in[i*8 +: 8];
                        m_ptr  = (i + 1) % 4;
                    end
                end
                q.push_back(e);
                m_last_data = e.data;
                m_last_id   = e.id;
                m_hold      = 1'b1;
                if (!quiet) $display("txn grant id=%0d data=%h", e.id, e.data);
            end else if (m_hold && out_ready) begin
                m_hold = 1'b0;
            end
        end
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        a_in[i*8 +: 8] = a;
        b_in[i*8 +: 8] = b;
    endtask

    task automatic pulse_reset();
        reset = 1'b1; req = '0;
        advance();
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b1111; out_ready = 1'b1;
        a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF0;
        advance();
        @(negedge clk);
        n_vec++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        advance();
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", out_data); end
        n_vec++; if (out_id !== 3'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", out_id); end
        n_vec++; if (op_count !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt: got %h want 0000", op_count); end
        req = '0; reset = 1'b0;
    endtask

    task automatic test_basic();
        req = 4'b0001; out_ready = 1'b1; set_ops(0, 8'hA5, 8'h0F);
        @(negedge clk);
        n_vec++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL basic_gnt: got %b want 0001", gnt); end
        advance();
        n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        n_vec++; if (out_data !== 8'hAA || out_data !== q[0].data) begin n_fail++; $display("FAIL basic_data: got %h want aa", out_data); end
        n_vec++; if (out_id !== 3'd0) begin n_fail++; $display("FAIL basic_id: got %0d want 0", out_id); end
        req = '0;
        @(negedge clk);
        n_vec++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt: got %b want 0000", gnt); end
        advance();
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== m_last_data || out_id !== m_last_id) begin n_fail++; $display("FAIL idle_hold: got %h/%0d want %h/%0d", out_data, out_id, m_last_data, m_last_id); end
        n_vec++; if (op_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL basic_cnt: got %0d want %0d", op_count, m_cnt); end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        req = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) set_ops(i, 8'($urandom), 8'($urandom));
            @(negedge clk);
            n_vec++; if (gnt !== 4'(1 << (k % 4)) || gnt !== model_gnt()) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, 4'(1 << (k % 4))); end
            advance();
            n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b want 1", k, out_valid); end
            n_vec++; if (out_data !== q[0].data || out_id !== 3'(k % 4)) begin n_fail++; $display("FAIL rr_out[%0d]: got %h/%0d want %h/%0d", k, out_data, out_id, q[0].data, k % 4); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        held = out_data;
        req = 4'b0100; out_ready = 1'b0; set_ops(2, 8'h5A, 8'hFF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL bp_gnt[%0d]: got %b want 0000", k, gnt); end
            advance();
            n_vec++; if (out_data !== held || out_valid !== 1'b1 || out_id !== 3'd3) begin n_fail++; $display("FAIL bp_stable[%0d]: got %h/%b/%0d want %h/1/3", k, out_data, out_valid, out_id, held); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL bp_release_gnt: got %b want 0100", gnt); end
        advance();
        n_vec++; if (out_id !== 3'd2 || out_data !== 8'hA5 || out_data !== q[0].data) begin n_fail++; $display("FAIL bp_release_out: got %h/%0d want a5/2", out_data, out_id); end
        n_vec++; if (op_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL bp_cnt: got %0d want %0d", op_count, m_cnt); end
        req = '0;
        advance();
    endtask

    task automatic test_reset_in_hold();
        pulse_reset();
        req = 4'b0001; out_ready = 1'b0; set_ops(0, 8'h3C, 8'h00);
        advance();
        n_vec++; if (out_data !== 8'h3C || out_valid !== 1'b1) begin n_fail++; $display("FAIL rih_load: got %h/%b want 3c/1", out_data, out_valid); end
        req = '0; reset = 1'b1;
        advance();
        reset = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 3'd0) begin n_fail++; $display("FAIL rih_clear: got %b/%h/%0d want 0/00/0", out_valid, out_data, out_id); end
        req = 4'b1010; out_ready = 1'b1; set_ops(1, 8'hF0, 8'h0F); set_ops(3, 8'h11, 8'h22);
        @(negedge clk);
        n_vec++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rih_gnt: got %b want 0010", gnt); end
        advance();
        n_vec++; if (out_id !== 3'd1 || out_data !== 8'hFF) begin n_fail++; $display("FAIL rih_out: got %h/%0d want ff/1", out_data, out_id); end
    endtask

    task automatic test_drop();
        // Holding id 1 with pointer at 2; requester 1 asks only while blocked, then leaves.
        req = 4'b0010; out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL drop_gnt[%0d]: got %b want 0000", k, gnt); end
            advance();
        end
        req = 4'b0000; out_ready = 1'b1;
        advance();
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid: got %b want 0", out_valid); end
        req = 4'b1111;
        @(negedge clk);
        n_vec++; if (gnt !== 4'b0100 || gnt !== model_gnt()) begin n_fail++; $display("FAIL drop_ptr: got %b want 0100", gnt); end
        advance();
        req = '0;
        advance();
    endtask

    task automatic test_counter();
        pulse_reset();
        req = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) advance();
        req = '0;
        advance();
        n_vec++; if (op_count !== (CNT_EN ? 16'd3 : 16'd0) || op_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL cnt_three: got %0d want %0d", op_count, CNT_EN ? 3 : 0); end
`ifdef XOR_ARB_CNT_EN
        quiet = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 65531; k++) advance();
        req = '0;
        advance();
        n_vec++; if (op_count !== 16'hFFFE) begin n_fail++; $display("FAIL cnt_fffe: got %h want fffe", op_count); end
        req = 4'b1111;
        for (int k = 0; k < 3; k++) advance();
        req = '0;
        advance();
        quiet = 1'b0;
        n_vec++; if (op_count !== 16'hFFFF || op_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL cnt_sat: got %h want ffff", op_count); end
`endif
    endtask

    initial begin
        reset = 1'b1; req = '0; out_ready = 1'b0; a_in = '0; b_in = '0;
        m_hold = 1'b0; m_ptr = 0; m_cnt = 0; m_last_data = '0; m_last_id = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_reset_in_hold();
        test_drop();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_arb.md
XOR_ARB -- requirements
Module: xor_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the XOR datapath, legal range 2..8.
REQ-002 Parameter WIDTH, default 8: operand and result width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NUM_REQ  per-requester request; held with operands until granted.
REQ-006 a_in  input  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 b_in  input  NUM_REQ*WIDTH  operand B, same packing as a_in.
REQ-008 gnt  output  NUM_REQ  one-hot grant, combinational; operands of the granted requester are captured on that edge.
REQ-009 out_valid  output  1  result available.
REQ-010 out_data  output  WIDTH  registered a XOR b of the granted requester.
REQ-011 out_id  output  3  index of the requester that owns out_data.
REQ-012 out_ready  input  1  consumer accepts the result when high with out_valid.
REQ-013 op_count  output  16  completed-transfer counter; see Configuration.

Function
REQ-014 The block SHALL have a two-state FSM: IDLE (no result held) and HOLD (result held in out_data).
REQ-015 gnt SHALL be non-zero only when req != 0 and (state == IDLE or (state == HOLD and out_ready == 1)).
REQ-016 Arbitration SHALL be round-robin: after granting i, the search starts at (i+1) mod NUM_REQ; the pointer advances only on a grant.
REQ-017 On a grant edge, out_data SHALL load a_i ^ b_i, out_id SHALL load i, out_valid SHALL be 1, and the next state SHALL be HOLD; latency from grant to out_valid is 1 cycle.
REQ-018 In HOLD with out_ready == 0, out_data, out_id, and out_valid SHALL remain stable, and gnt SHALL be 0.
REQ-019 In HOLD with out_ready == 1 and no req, the state SHALL go to IDLE, with out_valid = 0 next cycle.
REQ-020 In HOLD with out_ready == 1 and req != 0, the accept and the new grant SHALL occur on the same edge, giving a sustained throughput of 1 result per cycle.
REQ-021 A requester that drops req before being granted SHALL simply not be granted; no error is raised.
REQ-022 In IDLE, out_data and out_id SHALL hold their last values, and out_valid SHALL be 0.
REQ-023 The XOR SHALL be bitwise over WIDTH bits, with no carry and no sign handling.

Reset
REQ-024 While reset is high, the block SHALL drive state = IDLE, out_valid = 0, out_data = 0, out_id = 0, op_count = 0, and gnt = 0.
REQ-025 Reset SHALL set the round-robin pointer so that requester 0 has highest priority.
REQ-026 Reset asserted in HOLD SHALL discard the held result without an accept.

Configuration
REQ-027 Macro XOR_ARB_CNT_EN SHALL control the transfer counter.
REQ-028 With XOR_ARB_CNT_EN defined, op_count SHALL increment on each out_valid && out_ready edge and saturate at 16'hFFFF.
REQ-029 Without XOR_ARB_CNT_EN, op_count SHALL be tied to 16'h0000, and no counter flops are inferred.

Structure
REQ-030 Package xor_arb_pkg SHALL hold the FSM state encoding (IDLE = 0, HOLD = 1), the ID width constant (3), and the counter width constant (16).
REQ-031 The XOR itself SHALL be a single instance of sub-module xor8bit, fed by a NUM_REQ:1 operand mux.
REQ-032 For WIDTH > 8, the design SHALL instantiate WIDTH/8 xor8bit slices; WIDTH SHALL be a multiple of 8.

Verification
REQ-033 Scenario: after reset, req = 4'b0001, a0 = 8'hA5, b0 = 8'h0F, out_ready = 1 -> gnt = 4'b0001; next cycle out_valid = 1, out_data = 8'hAA, out_id = 0.
REQ-034 Scenario: req = 4'b1111 held, out_ready = 1 for 8 cycles -> grants in order 0, 1, 2, 3, 0, 1, 2, 3, with out_valid high continuously from the cycle after the first grant.
REQ-035 Scenario: a result is held and out_ready = 0 for 5 cycles while req = 4'b0100 -> gnt = 0 and out_data is stable; when out_ready rises, accept and a grant to requester 2 occur on the same edge.
REQ-036 Scenario: reset is asserted in HOLD with out_data = 8'h3C -> next cycle out_valid = 0, out_data = 0, and the next grant with req = 4'b1010 goes to requester 1.
REQ-037 Scenario: with XOR_ARB_CNT_EN defined and 3 accepted transfers, op_count = 3; from 16'hFFFE with 3 more accepts, op_count = 16'hFFFF. Without XOR_ARB_CNT_EN, op_count = 0 throughout.
REQ-038 Scenario: req = 4'b0010 is dropped before a grant (HOLD, out_ready = 0) -> requester 1 is never granted and the pointer is unchanged.
